psum_accum_quant: RTL
=====================

Name: psum_accum_quant

Overview:
- Sits directly downstream of the 12-MAC bank and takes its 48 partial sums per beat (12 MACs x 4 outputs, 20-bit signed each).
- Accumulates them over a programmable number of passes (input-channel groups).
- Applies a rounding arithmetic right shift, optional ReLU and int8 saturation, then presents one 48-lane int8 result word to the writeback stage over a valid/ready handshake.
- Back-pressures the MAC bank only when the final pass of a tile cannot enter the post-processing pipe.

Parameters:
- LANES, 48, number of partial-sum lanes (12 MACs x 4).
- PSUM_W, 20, signed width of each incoming partial sum.
- ACC_W, 28, signed accumulator width (PSUM_W + CNT_W).
- OUT_W, 8, signed output width per lane.
- CNT_W, 8, width of pass count; maximum passes 2^CNT_W-1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rstn  in  1  synchronous, active-high reset.
- vld_i  in  1  partial-sum beat valid from the MAC bank.
- oRdyUp  out  1  block can accept a beat; a beat transfers when vld_i & oRdyUp.
- iPsum  in  LANES*PSUM_W  lane k at bits [k*PSUM_W +: PSUM_W]; lane k = MAC k/4, output k%4.
- iNumPass  in  CNT_W  passes per tile; sampled on the first beat of a tile; value 0 is treated as 1.
- iShift  in  5  right-shift amount 0..27; sampled on the last beat.
- iRelu  in  1  ReLU enable; sampled on the last beat.
- oVld  out  1  output word valid.
- iRdy  in  1  downstream ready; the word transfers when oVld & iRdy.
- oDout  out  LANES*OUT_W  int8 result per lane, same lane packing as iPsum.
- oTileDone  out  1  one-cycle pulse on every output transfer.

Behaviour:
- Reset: all accumulators 0, pass_cnt 0, sum stage empty, oVld 0, oDout 0, oTileDone 0, oRdyUp 1. Reset mid-tile discards all partial data, and any pending output is dropped.
- Accepted beat (vld_i & oRdyUp):
  - If pass_cnt==0, latch npass = max(iNumPass, 1).
  - Each lane computes acc + sign_extend(psum).
  - If pass_cnt != npass-1: acc <= sum and pass_cnt++.
  - If pass_cnt == npass-1 (last beat): sum_reg <= sum, sum_vld <= 1, shift and relu are latched, acc <= 0, pass_cnt <= 0.
- A beat with vld_i=0 leaves all state unchanged. Gaps between beats are allowed at any point.
- Accumulator arithmetic is full two's complement at ACC_W. No overflow is possible for npass <= 255.
- Post stage, when sum_vld=1 and the output register is free (!oVld | iRdy), each lane computes in order:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (round half up, arithmetic shift).
  - If relu=1 and r<0, then r=0.
  - Saturate r to [-128, 127].
  - Load oDout, set oVld=1, clear sum_vld.
- Latency: the last beat accepted in cycle T gives oVld=1 in cycle T+2 if downstream is free.
- Output hold: oVld and oDout stay stable until iRdy. On an output transfer with no new word, oVld clears next cycle. The sum stage may refill oDout in the same cycle as a transfer (back-to-back words, no bubble).
- oRdyUp = !(pass_cnt==npass-1 & sum_vld & (oVld & !iRdy)).
  - Only a last beat can stall, and only when both the sum stage and the output register are occupied.
  - Non-last beats are always accepted, because accumulation of the next tile overlaps post-processing of the current one.
  - For the first beat of a tile, npass is taken from iNumPass in that cycle.
- Simultaneous events:
  - An output transfer plus a sum-stage load in the same cycle leaves oVld=1 with the new data.
  - A last beat accepted while the sum stage is draining in the same cycle is legal; sum_reg takes the new sum.
- npass=1: every beat is a last beat.

Decomposition:
- Shared package holds LANES, PSUM_W, ACC_W, OUT_W, CNT_W, the lane-packing index function and the int8 saturation limits.
- One natural sub-module: psum_quant_lane (combinational round/shift/ReLU/saturate for one lane), instantiated LANES times by generate.
- The FSM, counter and handshake stay in the top level.

Test Plan:
- iNumPass=3, shift 0, relu 0, all lanes psum 10,20,30, iRdy=1 -> oVld at T+2 after 3rd beat, every lane oDout=60, oTileDone pulse.
- iNumPass=1, lane0=-300, lane1=+300, lane2=-5, relu=1 -> lane0=0, lane1=127, lane2=0. Same input with relu=0 -> lane0=-128, lane1=127, lane2=-5.
- Rounding: shift=2, psums 6, -6, 5 -> outputs 2, -1, 1. shift=27, psum 2^19-1 over 255 passes -> 1.
- Back-pressure: iRdy=0, npass=1, 3 consecutive beats (values 1,2,3) -> oRdyUp drops low on the 3rd beat. Raise iRdy -> words 1,2,3 delivered in order, none lost or duplicated.
- npass=4 with vld_i gaps of random 0-3 cycles, lane psum alternating +0x7FFFF/-0x80000 -> exact 28-bit sum result, then correct saturation.
- Assert rstn mid-tile (after 2 of 4 beats) and while oVld=1 -> next cycle oVld=0, oDout=0, and the next tile restarts at pass 0 with a correct result.

Source files
------------

// File: rtl/psum_accum_quant_pkg.sv
// Shared sizing, lane packing and int8 limits for the partial-sum accumulate/quantise block.
package psum_accum_quant_pkg;
   localparam int LANES   = 48;
   localparam int PSUM_W  = 20;
   localparam int CNT_W   = 8;
   localparam int ACC_W   = PSUM_W + CNT_W;
   localparam int OUT_W   = 8;
   localparam int SHIFT_W = 5;

   localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
   localparam int SAT_MIN = -(1 << (OUT_W - 1));

   typedef struct packed {
      logic [SHIFT_W-1:0] shift;
      logic               relu;
   } post_cfg_t;

   // Lane k lives at bits [k*width +: width]; lane k = MAC k/4, output k%4.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction
endpackage

// File: rtl/psum_accum_quant_quant_lane.sv
// One lane of post-processing: rounding arithmetic right shift, optional ReLU, int8 saturation.
module psum_quant_lane
   import psum_accum_quant_pkg::*;
(
   input  logic signed [ACC_W-1:0]   sum_i,
   input  logic        [SHIFT_W-1:0] shift_i,
   input  logic                      relu_i,
   output logic signed [OUT_W-1:0]   q_o
);

   // One extra bit so the half-LSB bias can never wrap a near-max sum.
   function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] v,
                                                         input logic [SHIFT_W-1:0] sh);
      logic signed [ACC_W:0] ext;
      logic signed [ACC_W:0] bias;
      ext  = {v[ACC_W-1], v};
      bias = '0;
      if (sh != '0) begin
         bias = {{ACC_W{1'b0}}, 1'b1} << (sh - 1'b1);
      end
      return (ext + bias) >>> sh;
   endfunction

   function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W:0] v,
                                                        input logic relu);
      if (relu && (v < 0)) begin
         return '0;
      end
      if (v > SAT_MAX) begin
         return OUT_W'(SAT_MAX);
      end
      if (v < SAT_MIN) begin
         return OUT_W'(SAT_MIN);
      end
      return v[OUT_W-1:0];
   endfunction

   assign q_o = saturate(round_shift(sum_i, shift_i), relu_i);

endmodule

// File: rtl/psum_accum_quant.sv
// Accumulates 48-lane partial sums over a programmable pass count, then quantises to int8
// and hands the word downstream over valid/ready.
module psum_accum_quant
   import psum_accum_quant_pkg::*;
(
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      vld_i,
   output logic                      oRdyUp,
   input  logic [LANES*PSUM_W-1:0]   iPsum,
   input  logic [CNT_W-1:0]          iNumPass,
   input  logic [SHIFT_W-1:0]        iShift,
   input  logic                      iRelu,
   output logic                      oVld,
   input  logic                      iRdy,
   output logic [LANES*OUT_W-1:0]    oDout,
   output logic                      oTileDone
);

   logic [CNT_W-1:0]        pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]        npass_q, npass_d, npass_eff;
   logic                    sum_vld_q, sum_vld_d;
   logic                    vld_q, vld_d;
   post_cfg_t               cfg_q, cfg_d;
   logic signed [ACC_W-1:0] acc_q [LANES];
   logic signed [ACC_W-1:0] acc_d [LANES];
   logic signed [ACC_W-1:0] sum_q [LANES];
   logic signed [ACC_W-1:0] sum_d [LANES];
   logic signed [ACC_W-1:0] lane_sum [LANES];
   logic [LANES*OUT_W-1:0]  dout_q, dout_d, quant_w;
   logic                    last_beat, accept, out_free, post_fire;

   // The first beat of a tile takes its pass count straight from the input.
   always_comb begin
      npass_eff = npass_q;
      if (pass_cnt_q == '0) begin
         npass_eff = (iNumPass == '0) ? CNT_W'(1) : iNumPass;
      end
   end

   assign last_beat = (pass_cnt_q == (npass_eff - 1'b1));
   assign out_free  = !vld_q || iRdy;
   assign oRdyUp    = !(last_beat && sum_vld_q && !out_free);
   assign accept    = vld_i && oRdyUp;
   assign post_fire = sum_vld_q && out_free;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [PSUM_W-1:0] psum_w;
      assign psum_w      = iPsum[lane_lsb(k, PSUM_W) +: PSUM_W];
      assign lane_sum[k] = acc_q[k] + {{(ACC_W-PSUM_W){psum_w[PSUM_W-1]}}, psum_w};

      psum_quant_lane u_quant (
         .sum_i   (sum_q[k]),
         .shift_i (cfg_q.shift),
         .relu_i  (cfg_q.relu),
         .q_o     (quant_w[lane_lsb(k, OUT_W) +: OUT_W])
      );
   end

   // Stage 0 -> 1: accumulate, hand completed sums to the post stage.
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      npass_d    = npass_q;
      cfg_d      = cfg_q;
      sum_vld_d  = sum_vld_q;
      acc_d      = acc_q;
      sum_d      = sum_q;
      vld_d      = vld_q;
      dout_d     = dout_q;

      if (post_fire) begin
         sum_vld_d = 1'b0;
      end
      if (accept) begin
         npass_d = npass_eff;
         if (last_beat) begin
            sum_d      = lane_sum;
            sum_vld_d  = 1'b1;
            acc_d      = '{default: '0};
            pass_cnt_d = '0;
            cfg_d      = '{shift: iShift, relu: iRelu};
         end else begin
            acc_d      = lane_sum;
            pass_cnt_d = pass_cnt_q + 1'b1;
         end
      end

      // Stage 1 -> 2: quantised word into the output register.
      if (post_fire) begin
         dout_d = quant_w;
         vld_d  = 1'b1;
      end else if (iRdy) begin
         vld_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         pass_cnt_q <= '0;
         npass_q    <= '0;
         cfg_q      <= '0;
         sum_vld_q  <= 1'b0;
         vld_q      <= 1'b0;
         dout_q     <= '0;
         acc_q      <= '{default: '0};
      end else begin
         pass_cnt_q <= pass_cnt_d;
         npass_q    <= npass_d;
         cfg_q      <= cfg_d;
         sum_vld_q  <= sum_vld_d;
         vld_q      <= vld_d;
         dout_q     <= dout_d;
         acc_q      <= acc_d;
      end
   end

   always_ff @(posedge clk) begin
      sum_q <= sum_d;
   end

   assign oVld      = vld_q;
   assign oDout     = dout_q;
   assign oTileDone = vld_q && iRdy;

endmodule
